fifo_drain_ctrl: RTL

Read-side sequencer for the asynchronous FIFO. Pops one word at a time when the FIFO is non-empty and hands it to the serial transmitter with a single-cycle valid pulse. Tracks the transmitter's busy signal through one full frame, then inserts a programmable idle gap before the next pop. Sits in the rclk domain, between the FIFO read port and the transmitter.

---
 rtl/fifo_drain_ctrl_pkg.sv | 18 +
 rtl/drain_gap_timer.sv | 28 ++
 rtl/fifo_drain_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared definitions for the FIFO read-side drain sequencer.
// State encoding is fixed 3-bit binary so the value seen in waveforms maps directly to a state.
package fifo_drain_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_GAP_WIDTH  = 4;
    localparam int unsigned DEF_TO_WIDTH   = 5;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_POP       = 3'd1;
    localparam state_t ST_LAUNCH    = 3'd2;
    localparam state_t ST_WAIT_BUSY = 3'd3;
    localparam state_t ST_WAIT_DONE = 3'd4;
    localparam state_t ST_GAP       = 3'd5;

endpackage

// File: rtl/drain_gap_timer.sv
// Loadable down-counter shared by the inter-frame gap and the busy-rise timeout.
// Load wins over decrement; the count saturates at zero.
module drain_gap_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side sequencer: pops one FIFO word per frame, launches it to the transmitter,
// follows tx_busy through the frame and then waits a programmable idle gap.
module fifo_drain_ctrl
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned GAP_WIDTH  = DEF_GAP_WIDTH,
    parameter int unsigned TO_WIDTH   = DEF_TO_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_valid,
    output logic [15:0]           frame_cnt,
    output logic                  timeout_err,
    output logic                  idle
);

    localparam int unsigned TW = (GAP_WIDTH > TO_WIDTH) ? GAP_WIDTH : TO_WIDTH;
    // Down-count from 2^TO_WIDTH-2 so the zero flag fires on the (2^TO_WIDTH-1)th waiting edge.
    localparam logic [TW-1:0] TO_LOAD = TW'((1 << TO_WIDTH) - 2);

    state_t                state_q, state_d;
    logic                  rinc_q, valid_q, idle_q, err_q, err_set;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic [15:0]           frame_q;
    logic                  tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0]         tmr_val;

    drain_gap_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (rclk),
        .rst_n    (rrst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = TW'(gap_cycles);
        tmr_en   = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && !rempty && !tx_busy) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: state_d = ST_LAUNCH;
            ST_LAUNCH: begin
                state_d  = ST_WAIT_BUSY;
                tmr_load = 1'b1;
                tmr_val  = TO_LOAD;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmr_zero) begin
                    state_d  = ST_GAP;
                    err_set  = 1'b1;
                    tmr_load = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                end
            end
            ST_GAP: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they are registered yet aligned with the state.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q   <= ST_IDLE;
            rinc_q    <= 1'b0;
            valid_q   <= 1'b0;
            idle_q    <= 1'b1;
            err_q     <= 1'b0;
            tx_data_q <= '0;
            frame_q   <= '0;
        end else begin
            state_q <= state_d;
            rinc_q  <= (state_d == ST_POP);
            valid_q <= (state_d == ST_LAUNCH);
            idle_q  <= (state_d == ST_IDLE);
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (state_q == ST_POP) begin
                tx_data_q <= rdata;
            end
            if (state_q == ST_LAUNCH) begin
                frame_q <= frame_q + 16'd1;
            end
        end
    end

    assign rinc          = rinc_q;
    assign tx_data       = tx_data_q;
    assign tx_data_valid = valid_q;
    assign frame_cnt     = frame_q;
    assign timeout_err   = err_q;
    assign idle          = idle_q;

endmodule
